dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: pipeline MEM-stage port, secondary (debug/DMA) port and DMEM port.
// The arbiter uses the slave modport and the environment uses the master modport.
interface dmem_arbiter_if;
    // Pipeline MEM stage
    logic        p_rena;
    logic        p_wena;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [2:0]  p_store_select;
    logic [31:0] p_rdata;
    logic        stall_o;
    // Secondary requester: s_req is held until s_gnt pulses. The access completes in
    // the s_gnt cycle, and read data returns with an s_rvalid pulse one cycle later.
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_store_select;
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    // DMEM port
    logic        m_rena;
    logic        m_wena;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_store_select;
    logic [31:0] m_rdata;

    modport slave (
        input  p_rena, p_wena, p_addr, p_wdata, p_store_select,
        input  s_req, s_we, s_addr, s_wdata, s_store_select,
        input  m_rdata,
        output p_rdata, stall_o, s_gnt, s_rvalid, s_rdata,
        output m_rena, m_wena, m_addr, m_wdata, m_store_select
    );

    modport master (
        output p_rena, p_wena, p_addr, p_wdata, p_store_select,
        output s_req, s_we, s_addr, s_wdata, s_store_select,
        output m_rdata,
        input  p_rdata, stall_o, s_gnt, s_rvalid, s_rdata,
        input  m_rena, m_wena, m_addr, m_wdata, m_store_select
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: the pipeline has priority, and the secondary port uses idle cycles.
// Optional macro DMEM_ARB_STARVE_EN adds a starvation counter that forces a secondary grant and stalls the pipeline.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus,
    output logic [3:0]     dbg_starve_cnt
);
    logic        p_active;
    logic        force_s;
    logic        own_s;
    logic        stall;
    logic        s_read;
    logic        s_rvalid_q, s_rvalid_d;
    logic [31:0] s_rdata_q, s_rdata_d;

    assign p_active = bus.p_rena | bus.p_wena;

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_s        = (starve_cnt_q >= 4'(STARVE_LIMIT));
    assign stall          = own_s & p_active;
    assign dbg_starve_cnt = starve_cnt_q;

    // The counter counts denied request cycles and saturates at 15.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.s_req || own_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_s        = 1'b0;
    assign stall          = 1'b0;
    assign dbg_starve_cnt = 4'd0;
`endif

    always_comb begin
        own_s              = bus.s_req & (~p_active | force_s);
        bus.s_gnt          = own_s;
        bus.stall_o        = stall;
        bus.p_rdata        = bus.m_rdata;
        bus.m_rena         = 1'b0;
        bus.m_wena         = 1'b0;
        bus.m_addr         = 32'd0;
        bus.m_wdata        = 32'd0;
        bus.m_store_select = 3'd0;
        if (own_s) begin
            bus.m_rena         = ~bus.s_we;
            bus.m_wena         = bus.s_we;
            bus.m_addr         = bus.s_addr;
            bus.m_wdata        = bus.s_wdata;
            bus.m_store_select = bus.s_store_select;
        end else if (p_active) begin
            bus.m_rena         = bus.p_rena;
            bus.m_wena         = bus.p_wena;
            bus.m_addr         = bus.p_addr;
            bus.m_wdata        = bus.p_wdata;
            bus.m_store_select = bus.p_store_select;
        end
        s_read     = own_s & ~bus.s_we;
        s_rvalid_d = s_read;
        s_rdata_d  = s_read ? bus.m_rdata : s_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_rvalid_q <= 1'b0;
            s_rdata_q  <= 32'd0;
        end else begin
            s_rvalid_q <= s_rvalid_d;
            s_rdata_q  <= s_rdata_d;
        end
    end

    assign bus.s_rvalid = s_rvalid_q;
    assign bus.s_rdata  = s_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dmem_arbiter;
    localparam int unsigned LIM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_en = 1'b0;
    logic [3:0]  dbg_starve_cnt;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DMEM model ----------------
    logic [31:0] mem [0:63];

    assign bus.m_rdata = mem[bus.m_addr[7:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h5A00_0000 + 32'(i);
        end else if (bus.m_wena) begin
            mem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + compare ----------------
    int          m_cnt = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] exp_q[$];
    logic        p_act, forced, want_s;
    logic        e_rena, e_wena;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_sel;

    always @(negedge clk) begin
        if (chk_en) begin
            p_act = bus.p_rena | bus.p_wena;
`ifdef DMEM_ARB_STARVE_EN
            forced = (m_cnt >= int'(LIM));
`else
            forced = 1'b0;
`endif
            want_s = bus.s_req && (!p_act || forced);
            e_rena = 1'b0; e_wena = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_sel = 3'd0;
            if (want_s) begin
                e_rena = !bus.s_we; e_wena = bus.s_we; e_addr = bus.s_addr;
                e_wdata = bus.s_wdata; e_sel = bus.s_store_select;
            end else if (p_act) begin
                e_rena = bus.p_rena; e_wena = bus.p_wena; e_addr = bus.p_addr;
                e_wdata = bus.p_wdata; e_sel = bus.p_store_select;
            end
            if (exp_q.size() > 0) begin
                m_rvalid = 1'b1;
                m_rdata  = exp_q.pop_front();
            end else begin
                m_rvalid = 1'b0;
            end

            chk("s_gnt", 32'(bus.s_gnt), 32'(want_s));
            chk("stall_o", 32'(bus.stall_o), 32'(want_s && p_act));
            chk("m_rena", 32'(bus.m_rena), 32'(e_rena));
            chk("m_wena", 32'(bus.m_wena), 32'(e_wena));
            chk("m_addr", bus.m_addr, e_addr);
            chk("m_wdata", bus.m_wdata, e_wdata);
            chk("m_store_select", 32'(bus.m_store_select), 32'(e_sel));
            chk("p_rdata", bus.p_rdata, mem[e_addr[7:2]]);
            chk("s_rvalid", 32'(bus.s_rvalid), 32'(m_rvalid));
            chk("s_rdata", bus.s_rdata, m_rdata);
`ifdef DMEM_ARB_STARVE_EN
            chk("starve_cnt", 32'(dbg_starve_cnt), 32'(m_cnt));
`else
            chk("starve_cnt", 32'(dbg_starve_cnt), 32'd0);
`endif

            if (!rst_n) begin
                m_cnt   = 0;
                m_rdata = 32'd0;
                exp_q.delete();
            end else begin
                if (want_s && !bus.s_we) exp_q.push_back(mem[bus.s_addr[7:2]]);
                if (!bus.s_req || want_s) m_cnt = 0;
                else if (m_cnt < 15) m_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.p_rena = 1'b0; bus.p_wena = 1'b0; bus.p_addr = 32'd0;
        bus.p_wdata = 32'd0; bus.p_store_select = 3'd0;
        bus.s_req = 1'b0; bus.s_we = 1'b0; bus.s_addr = 32'd0;
        bus.s_wdata = 32'd0; bus.s_store_select = 3'd0;
    endtask

    task automatic drive_s(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.s_req = 1'b1; bus.s_we = we; bus.s_addr = addr;
        bus.s_wdata = data; bus.s_store_select = 3'd2;
    endtask

    task automatic drive_p(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.p_rena = re; bus.p_wena = we; bus.p_addr = addr;
        bus.p_wdata = data; bus.p_store_select = 3'd2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        rst_n = 1'b0;
        next_cycle();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset s_rvalid", 32'(bus.s_rvalid), 32'd0);
        chk("reset s_rdata", bus.s_rdata, 32'd0);
        chk("reset cnt", 32'(dbg_starve_cnt), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Secondary write then read back with the pipeline idle
        drive_s(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr s_gnt", 32'(bus.s_gnt), 32'd1);
        chk("wr m_wena", 32'(bus.m_wena), 32'd1);
        chk("wr m_addr", bus.m_addr, 32'h10);
        next_cycle();
        drive_s(1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk("rd s_gnt", 32'(bus.s_gnt), 32'd1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("rd s_rvalid", 32'(bus.s_rvalid), 32'd1);
        chk("rd s_rdata", bus.s_rdata, 32'hDEADBEEF);

        // Pipeline read wins against a pending secondary request
        next_cycle();
        drive_p(1'b1, 1'b0, 32'h20, 32'd0);
        drive_s(1'b0, 32'h40, 32'd0);
        @(negedge clk);
        chk("prio m_addr", bus.m_addr, 32'h20);
        chk("prio p_rdata", bus.p_rdata, 32'h5A000008);
        chk("prio s_gnt", 32'(bus.s_gnt), 32'd0);
        chk("prio stall", 32'(bus.stall_o), 32'd0);
        next_cycle();
        drive_idle();

        // Continuous pipeline traffic with a held secondary request
        next_cycle();
        drive_p(1'b1, 1'b0, 32'h24, 32'd0);
        drive_s(1'b0, 32'h44, 32'd0);
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("starve s_gnt", 32'(bus.s_gnt), 32'(c == 4));
            chk("starve stall", 32'(bus.stall_o), 32'(c == 4));
            if (c == 5) chk("starve p served", bus.m_addr, 32'h24);
            next_cycle();
        end
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("nostarve s_gnt", 32'(bus.s_gnt), 32'd0);
            chk("nostarve stall", 32'(bus.stall_o), 32'd0);
            next_cycle();
        end
        drive_p(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("idle s_gnt", 32'(bus.s_gnt), 32'd1);
        next_cycle();
`endif
        drive_idle();
        next_cycle();

        // Reset applied at the end of a read-grant cycle
        drive_s(1'b0, 32'h8, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst gnt", 32'(bus.s_gnt), 32'd1);
        next_cycle();
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst s_rvalid", 32'(bus.s_rvalid), 32'd0);
        chk("rst s_rdata", bus.s_rdata, 32'd0);
        chk("rst cnt", 32'(dbg_starve_cnt), 32'd0);

        // Four back-to-back secondary reads
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c <= 4) drive_s(1'b0, 32'((c - 1) * 4), 32'd0);
            else drive_idle();
            @(negedge clk);
            if (c <= 4) chk("b2b s_gnt", 32'(bus.s_gnt), 32'd1);
            if (c >= 2) begin
                chk("b2b s_rvalid", 32'(bus.s_rvalid), 32'd1);
                chk("b2b s_rdata", bus.s_rdata, 32'h5A000000 + 32'(c - 2));
            end
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst_n = ($urandom_range(0, 199) != 0);
            case ($urandom_range(0, 3))
                0: drive_p(1'b0, 1'b0, 32'd0, 32'd0);
                1, 3: drive_p(1'b1, 1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'd0);
                default: drive_p(1'b0, 1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            endcase
            bus.p_store_select = 3'($urandom_range(0, 7));
            bus.s_req = ($urandom_range(0, 2) != 0);
            bus.s_we = 1'($urandom_range(0, 1));
            bus.s_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            bus.s_wdata = $urandom;
            bus.s_store_select = 3'($urandom_range(0, 7));
        end
        next_cycle();
        drive_idle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
